// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Purpose:
//   Shared definitions for the memory port arbiter that sits between the
//   openmips core and the unified instruction/data memory. Provides the bus
//   widths used by the core, the enable/disable literals and the arbiter
//   state encoding.
//
// Contents:
//   InstAddrBus  - instruction address bus width
//   RegBus       - register / data bus width
//   ArbEnable    - active literal for single-bit enables
//   ArbDisable   - inactive literal for single-bit enables
//   arb_state_e  - 2-bit arbiter state encoding
//   is_busy()    - true while a bus cycle is outstanding
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int InstAddrBus = 32;
  localparam int RegBus      = 32;

  localparam logic ArbEnable  = 1'b1;
  localparam logic ArbDisable = 1'b0;

  typedef enum logic [1:0] {
    ArbIdle    = 2'b00,
    ArbBusyIf  = 2'b01,
    ArbBusyMem = 2'b10,
    ArbResp    = 2'b11
  } arb_state_e;

  // Both busy states hold the bus; the watchdog only runs while in one.
  function automatic logic is_busy(input arb_state_e state);
    return (state == ArbBusyIf) || (state == ArbBusyMem);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
//
// Purpose:
//   Counts the cycles a bus access has been outstanding and raises timeout_o
//   in the cycle that is the TIMEOUT-th busy cycle, so the arbiter can abort
//   a memory that never acknowledges. TIMEOUT = 0 disables the watchdog.
//
// Ports:
//   clk_i      in   system clock, rising edge
//   rst_ni     in   asynchronous reset, active-low
//   clear_i    in   restart the count (asserted when a new access is granted)
//   enable_i   in   count this cycle (asserted while the bus is busy)
//   timeout_o  out  combinational: this busy cycle is the last one allowed
// ---------------------------------------------------------------------------
module bus_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam logic WdActive = (TIMEOUT != 0) ? ArbEnable : ArbDisable;

  // The count holds the number of busy cycles already completed, so the
  // TIMEOUT-th busy cycle is the one where the count equals TIMEOUT-1.
  localparam logic [TO_W-1:0] LastCount = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Timeout decode for the current busy cycle.
  always_comb begin
    timeout_o = WdActive && enable_i && (count_q == LastCount);
  end

  // Next count: clear wins, then count busy cycles; stop once expired so
  // the counter can never wrap around and fire a second time.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !timeout_o) begin
      count_d = count_q + TO_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one external memory port between instruction fetch and the MEM
//   stage. Each access is granted in IDLE, holds the bus until bus_ack_i (or
//   the watchdog expires), then returns data with a one-cycle ack in RESP.
//   Data requests win over fetch requests. Stall requests to the pipeline
//   controller are combinational from req and ack.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (byte enables are DATA_W/8 wide)
//   TIMEOUT  busy cycles without bus_ack before abort; 0 disables
//   TO_W     watchdog counter width, must hold TIMEOUT
//
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   if_req_i, if_addr_i                 fetch request and address
//   if_rdata_o, if_ack_o                fetched word and completion pulse
//   mem_req_i, mem_we_i, mem_sel_i,
//   mem_addr_i, mem_wdata_i             data request fields
//   mem_rdata_o, mem_ack_o              read data and completion pulse
//   bus_stb_o, bus_we_o, bus_sel_o,
//   bus_addr_o, bus_wdata_o             memory bus request
//   bus_rdata_i, bus_ack_i              memory bus response
//   bus_err_o                           pulse with the ack of an aborted access
//   stallreq_if_o, stallreq_mem_o       pipeline stall requests
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = InstAddrBus,
  parameter int DATA_W  = RegBus,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_rdata_o,
  output logic                  if_ack_o,

  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [DATA_W/8-1:0]   mem_sel_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  mem_ack_o,

  output logic                  bus_stb_o,
  output logic                  bus_we_o,
  output logic [DATA_W/8-1:0]   bus_sel_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_wdata_o,
  input  logic [DATA_W-1:0]     bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic                  bus_err_o,

  output logic                  stallreq_if_o,
  output logic                  stallreq_mem_o
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e state_q, state_d;

  logic              busStb_q,   busStb_d;
  logic              busWe_q,    busWe_d;
  logic [SEL_W-1:0]  busSel_q,   busSel_d;
  logic [ADDR_W-1:0] busAddr_q,  busAddr_d;
  logic [DATA_W-1:0] busWdata_q, busWdata_d;
  logic              busErr_q,   busErr_d;
  logic              ifAck_q,    ifAck_d;
  logic              memAck_q,   memAck_d;
  logic [DATA_W-1:0] ifRdata_q,  ifRdata_d;
  logic [DATA_W-1:0] memRdata_q, memRdata_d;

  logic wdClear;
  logic wdEnable;
  logic wdTimeout;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_bus_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (wdClear),
    .enable_i  (wdEnable),
    .timeout_o (wdTimeout)
  );

  // The watchdog only advances while a bus cycle is outstanding.
  always_comb begin
    wdEnable = is_busy(state_q);
  end

  // Next-state and output logic. Acks, error and read data are one-cycle
  // values loaded on the way into RESP and defaulting back to zero, so the
  // rdata outputs are zero whenever no read ack is being presented.
  always_comb begin
    state_d    = state_q;
    busStb_d   = busStb_q;
    busWe_d    = busWe_q;
    busSel_d   = busSel_q;
    busAddr_d  = busAddr_q;
    busWdata_d = busWdata_q;
    busErr_d   = 1'b0;
    ifAck_d    = 1'b0;
    memAck_d   = 1'b0;
    ifRdata_d  = '0;
    memRdata_d = '0;
    wdClear    = 1'b0;

    unique case (state_q)
      ArbIdle: begin
        // The data request belongs to an older instruction; serving it first
        // keeps the pipeline from deadlocking on its own fetch.
        if (mem_req_i) begin
          state_d    = ArbBusyMem;
          busStb_d   = ArbEnable;
          busWe_d    = mem_we_i;
          busSel_d   = mem_sel_i;
          busAddr_d  = mem_addr_i;
          busWdata_d = mem_wdata_i;
          wdClear    = ArbEnable;
        end else if (if_req_i) begin
          state_d    = ArbBusyIf;
          busStb_d   = ArbEnable;
          busWe_d    = ArbDisable;
          busSel_d   = '1;
          busAddr_d  = if_addr_i;
          busWdata_d = '0;
          wdClear    = ArbEnable;
        end
      end

      ArbBusyIf, ArbBusyMem: begin
        // A real ack in the expiry cycle wins over the watchdog.
        if (bus_ack_i || wdTimeout) begin
          state_d  = ArbResp;
          busStb_d = ArbDisable;
          if (state_q == ArbBusyIf) begin
            ifAck_d = ArbEnable;
          end else begin
            memAck_d = ArbEnable;
          end
          if (bus_ack_i) begin
            if (!busWe_q) begin
              if (state_q == ArbBusyIf) begin
                ifRdata_d = bus_rdata_i;
              end else begin
                memRdata_d = bus_rdata_i;
              end
            end
          end else begin
            busErr_d = ArbEnable;
          end
        end
      end

      ArbResp: begin
        // No grant here: the acked requester needs this cycle to retire or
        // replace its request before it could be seen again.
        state_d = ArbIdle;
      end

      default: begin
        state_d  = ArbIdle;
        busStb_d = ArbDisable;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous so bus_stb drops the
  // moment reset asserts, abandoning any in-flight access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ArbIdle;
      busStb_q   <= 1'b0;
      busWe_q    <= 1'b0;
      busSel_q   <= '0;
      busAddr_q  <= '0;
      busWdata_q <= '0;
      busErr_q   <= 1'b0;
      ifAck_q    <= 1'b0;
      memAck_q   <= 1'b0;
      ifRdata_q  <= '0;
      memRdata_q <= '0;
    end else begin
      state_q    <= state_d;
      busStb_q   <= busStb_d;
      busWe_q    <= busWe_d;
      busSel_q   <= busSel_d;
      busAddr_q  <= busAddr_d;
      busWdata_q <= busWdata_d;
      busErr_q   <= busErr_d;
      ifAck_q    <= ifAck_d;
      memAck_q   <= memAck_d;
      ifRdata_q  <= ifRdata_d;
      memRdata_q <= memRdata_d;
    end
  end

  assign bus_stb_o   = busStb_q;
  assign bus_we_o    = busWe_q;
  assign bus_sel_o   = busSel_q;
  assign bus_addr_o  = busAddr_q;
  assign bus_wdata_o = busWdata_q;
  assign bus_err_o   = busErr_q;
  assign if_ack_o    = ifAck_q;
  assign if_rdata_o  = ifRdata_q;
  assign mem_ack_o   = memAck_q;
  assign mem_rdata_o = memRdata_q;

  // Stall requests are combinational so the pipeline releases in the ack cycle.
  assign stallreq_if_o  = if_req_i & ~ifAck_q;
  assign stallreq_mem_o = mem_req_i & ~memAck_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with the watchdog shortened to 4 busy
// cycles. Inputs change 1 time unit after each rising edge; outputs are
// checked on the following falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rstN;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifRdata;
  logic        ifAck;
  logic        memReq;
  logic        memWe;
  logic [3:0]  memSel;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;
  logic        busStb;
  logic        busWe;
  logic [3:0]  busSel;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [31:0] busRdata;
  logic        busAck;
  logic        busErr;
  logic        stallIf;
  logic        stallMem;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4),
    .TO_W    (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .if_req_i       (ifReq),
    .if_addr_i      (ifAddr),
    .if_rdata_o     (ifRdata),
    .if_ack_o       (ifAck),
    .mem_req_i      (memReq),
    .mem_we_i       (memWe),
    .mem_sel_i      (memSel),
    .mem_addr_i     (memAddr),
    .mem_wdata_i    (memWdata),
    .mem_rdata_o    (memRdata),
    .mem_ack_o      (memAck),
    .bus_stb_o      (busStb),
    .bus_we_o       (busWe),
    .bus_sel_o      (busSel),
    .bus_addr_o     (busAddr),
    .bus_wdata_o    (busWdata),
    .bus_rdata_i    (busRdata),
    .bus_ack_i      (busAck),
    .bus_err_o      (busErr),
    .stallreq_if_o  (stallIf),
    .stallreq_mem_o (stallMem)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, drive this cycle's inputs, then wait for the
  // falling edge where outputs are compared.
  task automatic applyStimulus(
    input logic        ifReqV,
    input logic [31:0] ifAddrV,
    input logic        memReqV,
    input logic        memWeV,
    input logic [3:0]  memSelV,
    input logic [31:0] memAddrV,
    input logic [31:0] memWdataV,
    input logic        busAckV,
    input logic [31:0] busRdataV
  );
    @(posedge clk);
    #1;
    ifReq    = ifReqV;
    ifAddr   = ifAddrV;
    memReq   = memReqV;
    memWe    = memWeV;
    memSel   = memSelV;
    memAddr  = memAddrV;
    memWdata = memWdataV;
    busAck   = busAckV;
    busRdata = busRdataV;
    @(negedge clk);
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rstN = 1'b1; ifReq = 1'b0; ifAddr = '0; memReq = 1'b0; memWe = 1'b0;
    memSel = '0; memAddr = '0; memWdata = '0; busAck = 1'b0; busRdata = '0;

    // ---------------- reset values ----------------
    #1 rstN = 1'b0;
    #1;
    checkOutput("rst_stb",      busStb,   0);
    checkOutput("rst_if_ack",   ifAck,    0);
    checkOutput("rst_mem_ack",  memAck,   0);
    checkOutput("rst_err",      busErr,   0);
    checkOutput("rst_if_rdata", ifRdata,  0);
    checkOutput("rst_addr",     busAddr,  0);
    checkOutput("rst_stallmem", stallMem, 0);
    ifReq = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold_stb", busStb,  0);
    checkOutput("rst_stallif",  stallIf, 1);
    ifReq = 1'b0;
    #2 rstN = 1'b1;

    // ---------------- fetch read, ack two cycles after stb ----------------
    applyStimulus(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("f1_c1_stall", stallIf, 1);
    checkOutput("f1_c1_stb",   busStb,  0);
    applyStimulus(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("f1_c2_stb",   busStb,  1);
    checkOutput("f1_c2_addr",  busAddr, 32'h100);
    checkOutput("f1_c2_we",    busWe,   0);
    checkOutput("f1_c2_sel",   busSel,  4'hF);
    checkOutput("f1_c2_stall", stallIf, 1);
    applyStimulus(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("f1_c3_stb",   busStb,  1);
    applyStimulus(1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 32'h24010001);
    checkOutput("f1_c4_stb",   busStb,  1);
    checkOutput("f1_c4_ack",   ifAck,   0);
    checkOutput("f1_c4_stall", stallIf, 1);
    applyStimulus(1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("f1_c5_ack",   ifAck,   1);
    checkOutput("f1_c5_rdata", ifRdata, 32'h24010001);
    checkOutput("f1_c5_stall", stallIf, 0);
    checkOutput("f1_c5_stb",   busStb,  0);
    checkOutput("f1_c5_mack",  memAck,  0);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("f1_c6_ack",   ifAck,   0);
    checkOutput("f1_c6_rdata", ifRdata, 0);

    // ---------------- simultaneous requests: mem write first ----------------
    applyStimulus(1, 32'h104, 1, 1, 4'hF, 32'h200, 32'hDEADBEEF, 0, 0);
    checkOutput("sim_stallif",  stallIf,  1);
    checkOutput("sim_stallmem", stallMem, 1);
    applyStimulus(1, 32'h104, 1, 1, 4'hF, 32'h200, 32'hDEADBEEF, 1, 32'h12345678);
    checkOutput("sim_w_stb",   busStb,   1);
    checkOutput("sim_w_we",    busWe,    1);
    checkOutput("sim_w_addr",  busAddr,  32'h200);
    checkOutput("sim_w_wdata", busWdata, 32'hDEADBEEF);
    applyStimulus(1, 32'h104, 1, 1, 4'hF, 32'h200, 32'hDEADBEEF, 0, 0);
    checkOutput("sim_w_mack",    memAck,   1);
    checkOutput("sim_w_mrdata",  memRdata, 0);
    checkOutput("sim_w_iack",    ifAck,    0);
    checkOutput("sim_w_stb_off", busStb,   0);
    checkOutput("sim_w_stallm",  stallMem, 0);
    checkOutput("sim_w_stalli",  stallIf,  1);
    applyStimulus(1, 32'h104, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("sim_idle_stb",  busStb, 0);
    checkOutput("sim_idle_mack", memAck, 0);
    applyStimulus(1, 32'h104, 0, 0, 4'h0, 0, 0, 1, 32'h11112222);
    checkOutput("sim_f_stb",  busStb,  1);
    checkOutput("sim_f_we",   busWe,   0);
    checkOutput("sim_f_addr", busAddr, 32'h104);
    applyStimulus(1, 32'h104, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("sim_f_ack",   ifAck,   1);
    checkOutput("sim_f_rdata", ifRdata, 32'h11112222);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // ---------------- byte write then fetch ----------------
    applyStimulus(1, 32'h108, 1, 1, 4'b0010, 32'h204, 32'h0000AB00, 0, 0);
    applyStimulus(1, 32'h108, 1, 1, 4'b0010, 32'h204, 32'h0000AB00, 1, 0);
    checkOutput("bw_sel", busSel, 4'b0010);
    checkOutput("bw_we",  busWe,  1);
    applyStimulus(1, 32'h108, 1, 1, 4'b0010, 32'h204, 32'h0000AB00, 0, 0);
    checkOutput("bw_mack", memAck, 1);
    applyStimulus(1, 32'h108, 0, 0, 4'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h108, 0, 0, 4'h0, 0, 0, 1, 32'hCAFEF00D);
    checkOutput("bwf_sel", busSel, 4'hF);
    checkOutput("bwf_we",  busWe,  0);
    applyStimulus(1, 32'h108, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("bwf_rdata", ifRdata, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // ---------------- watchdog abort, no bus_ack ----------------
    applyStimulus(0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0);
    checkOutput("to_stallmem", stallMem, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 32'hFFFF0000);
      checkOutput($sformatf("to_busy%0d_stb", i), busStb, 1);
      checkOutput($sformatf("to_busy%0d_ack", i), memAck, 0);
    end
    applyStimulus(0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 32'hFFFF0000);
    checkOutput("to_resp_stb",   busStb,   0);
    checkOutput("to_resp_ack",   memAck,   1);
    checkOutput("to_resp_err",   busErr,   1);
    checkOutput("to_resp_rdata", memRdata, 0);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("to_idle_err", busErr, 0);
    checkOutput("to_idle_stb", busStb, 0);

    // ---------------- bus_ack in the expiry cycle wins ----------------
    applyStimulus(0, 0, 1, 0, 4'hF, 32'h304, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 4'hF, 32'h304, 0, 0, 0);
    end
    applyStimulus(0, 0, 1, 0, 4'hF, 32'h304, 0, 1, 32'h55AA55AA);
    checkOutput("aw_last_stb", busStb, 1);
    applyStimulus(0, 0, 1, 0, 4'hF, 32'h304, 0, 0, 0);
    checkOutput("aw_ack",   memAck,   1);
    checkOutput("aw_err",   busErr,   0);
    checkOutput("aw_rdata", memRdata, 32'h55AA55AA);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // ---------------- async reset mid-busy ----------------
    applyStimulus(1, 32'h3F0, 0, 0, 4'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h3F0, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("ar_busy_stb", busStb, 1);
    #1 rstN = 1'b0;
    #1;
    checkOutput("ar_async_stb", busStb, 0);
    ifReq = 1'b0;
    @(negedge clk);
    #1 rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("ar_post_ack", ifAck,  0);
    checkOutput("ar_post_stb", busStb, 0);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("ar_post2_ack", ifAck, 0);
    applyStimulus(1, 32'h400, 0, 0, 4'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h400, 0, 0, 4'h0, 0, 0, 1, 32'h8C220004);
    checkOutput("ar_new_stb",  busStb,  1);
    checkOutput("ar_new_addr", busAddr, 32'h400);
    applyStimulus(1, 32'h400, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("ar_new_ack",   ifAck,   1);
    checkOutput("ar_new_rdata", ifRdata, 32'h8C220004);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // ---------------- back-to-back fetches, ack in first busy cycle ----------------
    applyStimulus(1, 32'h500, 0, 0, 4'h0, 0, 0, 0, 0);
    applyStimulus(1, 32'h500, 0, 0, 4'h0, 0, 0, 1, 32'hA0A0A0A0);
    checkOutput("bb1_stb",  busStb,  1);
    checkOutput("bb1_addr", busAddr, 32'h500);
    applyStimulus(1, 32'h500, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("bb1_ack",   ifAck,   1);
    checkOutput("bb1_rdata", ifRdata, 32'hA0A0A0A0);
    checkOutput("bb1_nodup", busStb,  0);
    applyStimulus(1, 32'h504, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("bb2_idle_stb", busStb, 0);
    checkOutput("bb2_idle_ack", ifAck,  0);
    applyStimulus(1, 32'h504, 0, 0, 4'h0, 0, 0, 1, 32'hB1B1B1B1);
    checkOutput("bb2_stb",  busStb,  1);
    checkOutput("bb2_addr", busAddr, 32'h504);
    applyStimulus(1, 32'h504, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("bb2_ack",   ifAck,   1);
    checkOutput("bb2_rdata", ifRdata, 32'hB1B1B1B1);
    applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    checkOutput("bb_end_stb", busStb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
